// File: rtl/bus_arb_pkg.sv
// Shared constants for the bus arbiter: FSM state encoding, default parameters
// and the winner-index width helper.
package bus_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int DEF_N_CLIENTS      = 4;
  localparam int DEF_DATA_WIDTH     = 8;
  localparam int DEF_ADDR_WIDTH     = 4;
  localparam int DEF_TIMEOUT_CYCLES = 32;

  // A client index always needs at least one bit, even for two clients.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: the search starts one past last_idx and
// wraps modulo N. It returns the first requester as a one-hot grant and as an index.
module rr_picker
  import bus_arb_pkg::*;
#(
  parameter int N     = DEF_N_CLIENTS,
  parameter int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_idx,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  int cand;

  // NOTE: every output gets a default before the loop, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    cand    = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(last_idx) + k) % N;
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter that lets N clients share one ram port (IDLE -> REQ -> DONE).
// Define BUS_ARB_TIMEOUT_EN to add a watchdog that ends a stalled REQ and pulses err.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int N_CLIENTS      = DEF_N_CLIENTS,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [N_CLIENTS-1:0]            c_rq,
  input  logic [N_CLIENTS-1:0]            c_wr_ni,
  input  logic [N_CLIENTS*ADDR_WIDTH-1:0] c_address,
  input  logic [N_CLIENTS*DATA_WIDTH-1:0] c_dataW,
  output logic [N_CLIENTS-1:0]            c_ack,
  output logic [DATA_WIDTH-1:0]           c_dataR,
  output logic [N_CLIENTS-1:0]            grant,
  output logic                            err,
  output logic                            m_rq,
  output logic                            m_wr_ni,
  output logic [ADDR_WIDTH-1:0]           m_address,
  output logic [DATA_WIDTH-1:0]           m_dataW,
  input  logic                            m_ack,
  input  logic [DATA_WIDTH-1:0]           m_dataR
);

  localparam int IDX_W = idx_width(N_CLIENTS);

  logic [1:0]            state_q,    state_d;
  logic [N_CLIENTS-1:0]  grant_q,    grant_d;
  logic [N_CLIENTS-1:0]  c_ack_q,    c_ack_d;
  logic [IDX_W-1:0]      win_q,      win_d;
  logic [DATA_WIDTH-1:0] c_data_r_q, c_data_r_d;
  logic                  err_q,      err_d;

  logic [N_CLIENTS-1:0]  pick_gnt;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_any;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TIMEOUT_CYCLES > 0);
`endif

  rr_picker #(
    .N     (N_CLIENTS),
    .IDX_W (IDX_W)
  ) u_rr_picker (
    .req      (c_rq),
    .last_idx (win_q),
    .gnt      (pick_gnt),
    .gnt_idx  (pick_idx),
    .any      (pick_any)
  );

  // win_q is both the current owner and, between transactions, last_winner.
  assign m_rq      = (state_q == ST_REQ);
  assign m_wr_ni   = c_wr_ni[win_q];
  assign m_address = c_address[win_q*ADDR_WIDTH +: ADDR_WIDTH];
  assign m_dataW   = c_dataW[win_q*DATA_WIDTH +: DATA_WIDTH];

  assign c_ack   = c_ack_q;
  assign c_dataR = c_data_r_q;
  assign grant   = grant_q;
  assign err     = err_q;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    win_d      = win_q;
    c_ack_d    = '0;
    c_data_r_d = c_data_r_q;
    err_d      = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
    tmo_d      = tmo_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick_gnt;
          win_d   = pick_idx;
          state_d = ST_REQ;
`ifdef BUS_ARB_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
      end
      ST_REQ: begin
        // c_rq is not looked at here: a dropped request still completes.
        if (m_ack) begin
          if (m_wr_ni) c_data_r_d = m_dataR;
          c_ack_d = grant_q;
          state_d = ST_DONE;
        end
`ifdef BUS_ARB_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TIMEOUT_CYCLES)) begin
          c_ack_d = grant_q;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      ST_DONE: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values computed before this edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      c_ack_q    <= '0;
      win_q      <= IDX_W'(N_CLIENTS - 1);
      c_data_r_q <= '0;
      err_q      <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
      tmo_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      c_ack_q    <= c_ack_d;
      win_q      <= win_d;
      c_data_r_q <= c_data_r_d;
      err_q      <= err_d;
`ifdef BUS_ARB_TIMEOUT_EN
      tmo_q      <= tmo_d;
`endif
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with a 4-client setup and a small ram model
// that acknowledges after a delay of 2. The timeout case runs when BUS_ARB_TIMEOUT_EN is defined.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  c_rq, c_wr_ni, c_ack, grant;
  logic [15:0] c_address;
  logic [31:0] c_dataW;
  logic [7:0]  c_dataR;
  logic        err, m_rq, m_wr_ni, m_ack;
  logic [3:0]  m_address;
  logic [7:0]  m_dataW, m_dataR;

  logic        ram_block;
  logic [1:0]  ram_cnt;
  logic [7:0]  mem [16];

  int n_checks = 0;
  int n_fails  = 0;
  int cyc;

  always #5 clk = ~clk;

  bus_arbiter #(
    .N_CLIENTS      (4),
    .DATA_WIDTH     (8),
    .ADDR_WIDTH     (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .c_rq      (c_rq),
    .c_wr_ni   (c_wr_ni),
    .c_address (c_address),
    .c_dataW   (c_dataW),
    .c_ack     (c_ack),
    .c_dataR   (c_dataR),
    .grant     (grant),
    .err       (err),
    .m_rq      (m_rq),
    .m_wr_ni   (m_wr_ni),
    .m_address (m_address),
    .m_dataW   (m_dataW),
    .m_ack     (m_ack),
    .m_dataR   (m_dataR)
  );

  // Ram model: m_ack registers high once m_rq has been held for two cycles,
  // and clears when m_rq drops. ram_block suppresses the acknowledge.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_cnt <= 2'd0;
      m_ack   <= 1'b0;
      m_dataR <= 8'h00;
      mem[3]  <= 8'h5A;
    end else if (!m_rq) begin
      ram_cnt <= 2'd0;
      m_ack   <= 1'b0;
    end else if (ram_cnt == 2'd2) begin
      if (!ram_block) begin
        m_ack <= 1'b1;
        if (m_wr_ni) m_dataR <= mem[m_address];
        else         mem[m_address] <= m_dataW;
      end
    end else begin
      ram_cnt <= ram_cnt + 2'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycles from the current one until c_ack is seen; -1 if it never arrives.
  task automatic wait_ack(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      n++;
      if (c_ack != 4'b0000) return;
    end
    n = -1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    reset_n   = 1'b0;
    c_rq      = 4'b0000;
    c_wr_ni   = 4'b1111;
    c_address = 16'h0000;
    c_dataW   = 32'h0;
    ram_block = 1'b0;
    repeat (2) tick();
    check("rst_grant", grant, 4'b0000);
    check("rst_ack",   c_ack, 4'b0000);
    check("rst_dataR", c_dataR, 8'h00);
    check("rst_err",   err, 1'b0);
    check("rst_m_rq",  m_rq, 1'b0);
    reset_n = 1'b1;
    tick();

    // Single read: client 1, address 3 holds 0x5A.
    c_address[7:4] = 4'd3;
    c_rq = 4'b0010;
    tick();
    check("rd_grant",  grant, 4'b0010);
    check("rd_m_rq",   m_rq, 1'b1);
    check("rd_m_addr", m_address, 4'd3);
    check("rd_m_wrni", m_wr_ni, 1'b1);
    wait_ack(cyc);
    check("rd_latency", cyc, 4);
    check("rd_ack",     c_ack, 4'b0010);
    check("rd_dataR",   c_dataR, 8'h5A);
    check("rd_err",     err, 1'b0);
    check("done_m_rq",  m_rq, 1'b0);
    c_rq = 4'b0000;
    tick();
    check("ack_pulse",  c_ack, 4'b0000);
    check("idle_grant", grant, 4'b0000);
    check("idle_m_rq",  m_rq, 1'b0);

    // Write 0xC3 to address 2 from client 2, then read it back with c_rq held.
    c_address[11:8] = 4'd2;
    c_dataW[23:16]  = 8'hC3;
    c_wr_ni[2]      = 1'b0;
    c_rq            = 4'b0100;
    tick();
    check("wr_grant",  grant, 4'b0100);
    check("wr_m_wrni", m_wr_ni, 1'b0);
    check("wr_m_data", m_dataW, 8'hC3);
    check("wr_m_addr", m_address, 4'd2);
    wait_ack(cyc);
    check("wr_latency", cyc, 4);
    check("wr_ack",     c_ack, 4'b0100);
    check("wr_dataR_kept", c_dataR, 8'h5A);
    check("b2b_gap_done",  m_rq, 1'b0);
    c_wr_ni[2] = 1'b1;
    tick();
    check("b2b_gap_idle",  m_rq, 1'b0);
    check("b2b_idle_grant", grant, 4'b0000);
    wait_ack(cyc);
    check("b2b_latency", cyc, 5);
    check("b2b_ack",     c_ack, 4'b0100);
    check("b2b_dataR",   c_dataR, 8'hC3);
    c_rq = 4'b0000;
    tick();

    // Client 3 drops c_rq in REQ while client 1 raises it: grant must not move.
    c_address[15:12] = 4'd3;
    c_rq = 4'b1000;
    tick();
    check("drop_grant", grant, 4'b1000);
    c_rq = 4'b0010;
    tick();
    check("drop_grant_held", grant, 4'b1000);
    wait_ack(cyc);
    check("drop_latency", cyc, 3);
    check("drop_ack",     c_ack, 4'b1000);
    check("drop_dataR",   c_dataR, 8'h5A);
    c_rq = 4'b0000;
    tick();

    // All four requesting: last winner is 3, so order is 0,1,2,3,0.
    c_rq = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_ack(cyc);
      check("rr_latency", cyc, (k == 0) ? 5 : 6);
      check("rr_order",   c_ack, 4'b0001 << (k % 4));
    end
    c_rq = 4'b0000;
    tick();

    // Reset in the middle of REQ aborts at once; client 0 then wins first.
    c_rq = 4'b0100;
    tick();
    check("pre_rst_grant", grant, 4'b0100);
    tick();
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_m_rq",  m_rq, 1'b0);
    check("mid_rst_grant", grant, 4'b0000);
    check("mid_rst_ack",   c_ack, 4'b0000);
    c_rq = 4'b0101;
    tick();
    tick();
    check("in_rst_ack", c_ack, 4'b0000);
    reset_n = 1'b1;
    tick();
    check("post_rst_grant", grant, 4'b0001);
    wait_ack(cyc);
    check("post_rst_latency", cyc, 4);
    check("post_rst_ack",     c_ack, 4'b0001);
    c_rq = 4'b0100;
    tick();
    wait_ack(cyc);
    check("post_rst_c2_latency", cyc, 5);
    check("post_rst_c2_ack",     c_ack, 4'b0100);
    check("post_rst_c2_dataR",   c_dataR, 8'hC3);
    check("post_rst_err",        err, 1'b0);
    c_rq = 4'b0000;
    tick();

`ifdef BUS_ARB_TIMEOUT_EN
    // Watchdog: ram never acks; err and c_ack pulse 9 cycles after REQ entry.
    ram_block = 1'b1;
    c_rq = 4'b0010;
    wait_ack(cyc);
    check("tmo_latency", cyc, 10);
    check("tmo_err",     err, 1'b1);
    check("tmo_ack",     c_ack, 4'b0010);
    check("tmo_dataR",   c_dataR, 8'hC3);
    c_rq = 4'b0000;
    tick();
    check("tmo_err_pulse", err, 1'b0);
    check("tmo_idle_m_rq", m_rq, 1'b0);
    check("tmo_idle_grant", grant, 4'b0000);
    ram_block = 1'b0;
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter N_CLIENTS, default 4: number of requesting clients, range 2..8.
REQ-002 Parameter DATA_WIDTH, default 8: data bus width, matching the shared ram.
REQ-003 Parameter ADDR_WIDTH, default 4: address width, matching the shared ram.
REQ-004 Parameter TIMEOUT_CYCLES, default 32: watchdog limit, used only when BUS_ARB_TIMEOUT_EN is defined.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset_n  input  1  reset; asynchronous, active-low.
REQ-007 c_rq  input  N_CLIENTS  per-client request, held high until the matching c_ack.
REQ-008 c_wr_ni  input  N_CLIENTS  per-client operation select; 1 = read, 0 = write.
REQ-009 c_address  input  N_CLIENTS*ADDR_WIDTH  packed per-client addresses; client i in slice i.
REQ-010 c_dataW  input  N_CLIENTS*DATA_WIDTH  packed per-client write data.
REQ-011 c_ack  output  N_CLIENTS  registered one-cycle completion pulse, at most one bit set.
REQ-012 c_dataR  output  DATA_WIDTH  registered read data, shared by all clients.
REQ-013 grant  output  N_CLIENTS  one-hot owner of the ram port; all zero when idle.
REQ-014 err  output  1  one-cycle pulse marking a timed-out transaction.
REQ-015 m_rq / m_wr_ni / m_address / m_dataW  output  1/1/ADDR_WIDTH/DATA_WIDTH  ram request side.
REQ-016 m_ack / m_dataR  input  1/DATA_WIDTH  ram acknowledge and read data.

Function
REQ-017 The FSM SHALL have three states: IDLE, REQ and DONE.
REQ-018 IDLE: if any c_rq bit is set, pick a winner round-robin, register grant and go to REQ; otherwise stay in IDLE.
REQ-019 Round-robin: the search SHALL start at last_winner+1 (mod N_CLIENTS); the winner becomes last_winner.
REQ-020 REQ: m_rq=1; m_wr_ni, m_address and m_dataW SHALL be muxed from the granted client.
REQ-021 REQ: while m_ack=1, latch m_dataR into c_dataR (reads only) and go to DONE.
REQ-022 DONE: m_rq=0, so the ram delay counter clears; c_ack[winner]=1 for exactly this cycle; grant is cleared on exit; next state is IDLE.
REQ-023 Latency: with ram ack delay D, c_ack SHALL be high D+3 cycles after the IDLE cycle that sampled c_rq.
REQ-024 Outside REQ, m_rq SHALL be 0; m_rq SHALL be low for at least two cycles between transactions (DONE, IDLE).
REQ-025 A client whose c_rq drops while in REQ SHALL NOT abort the transaction; c_ack is still issued.
REQ-026 A write SHALL leave c_dataR unchanged.
REQ-027 c_rq changes while not in IDLE SHALL NOT affect grant.

Reset
REQ-028 While reset_n=0: state=IDLE, grant=0, c_ack=0, c_dataR=0, err=0, m_rq=0, last_winner=N_CLIENTS-1, so client 0 wins first.
REQ-029 Reset mid-transaction SHALL abort immediately and issue no c_ack.

Configuration
REQ-030 With BUS_ARB_TIMEOUT_EN defined, a counter SHALL run in REQ; after TIMEOUT_CYCLES cycles without m_ack, go to DONE with c_ack[winner]=1 and err=1, leaving c_dataR unchanged.
REQ-031 Without BUS_ARB_TIMEOUT_EN, there SHALL be no watchdog logic, err SHALL be tied 0, and REQ waits indefinitely.

Structure
REQ-032 Package bus_arb_pkg SHALL hold the state encoding and default parameter constants.
REQ-033 Sub-module rr_picker SHALL compute the one-hot winner combinationally from the request vector and last_winner.

Verification (ram instance with DELAY_ACK=2, N_CLIENTS=4)
REQ-034 Single read: client 1 requests address 3, which holds 0x5A -> c_ack[1] five cycles after the IDLE sample, c_dataR=0x5A.
REQ-035 Write then read: client 2 writes 0xC3 to address 2, then reads address 2 -> c_dataR=0xC3; c_dataR is unchanged after the write.
REQ-036 All four c_rq held high -> grants in order 0,1,2,3,0; no client is granted twice before the others are served.
REQ-037 Reset asserted in REQ -> m_rq, grant and c_ack are 0 at once; after release, client 0 wins first.
REQ-038 BUS_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, m_ack forced to 0 -> err and c_ack pulse together 9 cycles after REQ entry; the FSM returns to IDLE.
REQ-039 Back-to-back requests from one client -> m_rq is low for at least two cycles between the two transactions, and both transactions complete.
